// File: rtl/lpc_analysis_filt.sv
// LPC analysis (prediction-error) filter: e[n] = x[n] + sum a_k*x[n-k],
// Q2.14 coefficients, one shared MAC, valid/ready on both sides.
module lpc_analysis_filt #(
  parameter int unsigned ORDER = 10,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned FRAC  = 14,
  parameter int unsigned AW    = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x,
  input  logic                 coef_wr,
  input  logic [3:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_commit,
  input  logic                 hist_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] e,
  output logic                 sat
);

  localparam int unsigned PW = CW + DW;
  localparam logic signed [AW-1:0] EMAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] EMIN = -EMAX - AW'(1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [CW-1:0] shadow [1:ORDER];
  logic signed [CW-1:0] active [1:ORDER];
  logic signed [DW-1:0] hist   [1:ORDER];
  logic signed [DW-1:0] x_reg;
  logic signed [AW-1:0] acc;
  logic [3:0]           k;
  logic                 commit_pend;
  logic                 clr_pend;

  logic                 accept;
  logic                 last_tap;
  logic                 wr_ok;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] acc_sh;
  logic signed [DW-1:0] e_c;
  logic                 sat_c;

  // Handshake and tap control decode
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign last_tap = (k == 4'(ORDER));
  assign wr_ok    = coef_wr && (coef_addr >= 4'd1) && (coef_addr <= 4'(ORDER));

  // MAC term, final scaling and saturation of the running sum
  always_comb begin
    prod    = $signed(PW'(active[k])) * $signed(PW'(hist[k]));
    acc_sum = acc + AW'(prod);
    acc_sh  = acc_sum >>> FRAC;
    e_c     = acc_sh[DW-1:0];
    sat_c   = 1'b0;
    if (acc_sh > EMAX) begin
      e_c   = EMAX[DW-1:0];
      sat_c = 1'b1;
    end else if (acc_sh < EMIN) begin
      e_c   = EMIN[DW-1:0];
      sat_c = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = MAC;
      MAC:     if (last_tap)  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: accumulator, history, coefficient banks, output register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= ORDER; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        hist[i]   <= '0;
      end
      x_reg       <= '0;
      acc         <= '0;
      k           <= '0;
      commit_pend <= 1'b0;
      clr_pend    <= 1'b0;
      out_valid   <= 1'b0;
      e           <= '0;
      sat         <= 1'b0;
    end else begin
      if (wr_ok) shadow[coef_addr] <= coef_data;

      // Bank swap only at sample boundaries so a running sample sees one bank
      if (state == IDLE && coef_commit) begin
        for (int i = 1; i <= ORDER; i++) active[i] <= shadow[i];
      end else if (state == OUT && out_ready && (commit_pend || coef_commit)) begin
        for (int i = 1; i <= ORDER; i++) active[i] <= shadow[i];
        commit_pend <= 1'b0;
      end else if (coef_commit) begin
        commit_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (hist_clr) begin
            for (int i = 1; i <= ORDER; i++) hist[i] <= '0;
          end
          if (accept) begin
            x_reg <= x;
            acc   <= AW'(x) <<< FRAC;
            k     <= 4'd1;
          end
        end
        MAC: begin
          acc <= acc_sum;
          k   <= k + 4'd1;
          if (last_tap) begin
            e         <= e_c;
            sat       <= sat_c;
            out_valid <= 1'b1;
            clr_pend  <= 1'b0;
            // A clear seen during MAC lands after this sample's shift
            if (clr_pend || hist_clr) begin
              for (int i = 1; i <= ORDER; i++) hist[i] <= '0;
            end else begin
              for (int i = 2; i <= ORDER; i++) hist[i] <= hist[i-1];
              hist[1] <= x_reg;
            end
          end else if (hist_clr) begin
            clr_pend <= 1'b1;
          end
        end
        OUT: begin
          if (hist_clr) begin
            for (int i = 1; i <= ORDER; i++) hist[i] <= '0;
          end
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_analysis_filt.sv
// Self-checking bench for lpc_analysis_filt against an arithmetic reference model.
module tb_lpc_analysis_filt;

  localparam int ORDER = 10;
  localparam int DW    = 16;
  localparam int FRAC  = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x;
  logic                 coef_wr;
  logic [3:0]           coef_addr;
  logic signed [15:0]   coef_data;
  logic                 coef_commit;
  logic                 hist_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] e;
  logic                 sat;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state: coefficient banks and past samples, most recent first
  int m_shadow [1:15];
  int m_active [1:15];
  int m_hist   [$];

  lpc_analysis_filt #(.ORDER(ORDER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .hist_clr(hist_clr), .out_valid(out_valid),
    .out_ready(out_ready), .e(e), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    for (int i = 1; i <= 15; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_hist.delete();
  endfunction

  // e = floor((x*2^FRAC + sum a_k*x[n-k]) / 2^FRAC), clipped to DW bits
  function automatic void model_step(input int xv, output int ee, output int ss);
    longint acc;
    longint v;
    longint h;
    acc = longint'(xv) * (longint'(1) << FRAC);
    for (int i = 1; i <= ORDER; i++) begin
      h = (i <= m_hist.size()) ? longint'(m_hist[i-1]) : 64'sd0;
      acc += longint'(m_active[i]) * h;
    end
    v  = acc >>> FRAC;
    ss = 0;
    ee = int'(v);
    if (v > 32767)       begin ee = 32767;  ss = 1; end
    else if (v < -32768) begin ee = -32768; ss = 1; end
    m_hist.push_front(xv);
    if (m_hist.size() > ORDER) void'(m_hist.pop_back());
  endfunction

  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    coef_wr = 1'b1; coef_addr = 4'(a); coef_data = 16'(d);
    @(negedge clk);
    coef_wr = 1'b0;
    if (a >= 1 && a <= ORDER) m_shadow[a] = d;
  endtask

  task automatic commit();
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    for (int i = 1; i <= 15; i++) m_active[i] = m_shadow[i];
  endtask

  // Write and commit on the same edge: the bank committed is the pre-write one
  task automatic wr_commit(input int a, input int d);
    @(negedge clk);
    coef_wr = 1'b1; coef_commit = 1'b1; coef_addr = 4'(a); coef_data = 16'(d);
    @(negedge clk);
    coef_wr = 1'b0; coef_commit = 1'b0;
    for (int i = 1; i <= 15; i++) m_active[i] = m_shadow[i];
    if (a >= 1 && a <= ORDER) m_shadow[a] = d;
  endtask

  task automatic clear_hist();
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    m_hist.delete();
  endtask

  // One sample end to end; cc/hc pulse commit/hist_clr at that MAC cycle (-1 = none)
  task automatic run_sample(input int xv, input int stall, input int cc, input int hc);
    int ee;
    int ss;
    int lat;
    int guard;
    model_step(xv, ee, ss);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", in_ready, 1);
    x = 16'(xv); in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; x = '0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      coef_commit = (lat == cc);
      hist_clr    = (lat == hc);
      @(posedge clk); #1;
      lat++;
    end
    coef_commit = 1'b0; hist_clr = 1'b0;
    // accept edge plus ORDER MAC edges: out_valid in cycle T+ORDER+1
    check("latency", lat, ORDER);
    check("e", e, ee);
    check("sat", sat, ss);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_e", e, ee);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", out_valid, 0);
    if (cc >= 0) for (int i = 1; i <= 15; i++) m_active[i] = m_shadow[i];
    if (hc >= 0) m_hist.delete();
  endtask

  initial begin
    int seen;
    int xr;
    rst = 1'b1; in_valid = 1'b1; x = 16'sd777; coef_wr = 1'b0; coef_addr = '0;
    coef_data = '0; coef_commit = 1'b0; hist_clr = 1'b0; out_ready = 1'b1;
    model_reset();

    // Reset held with in_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_e", e, 0);
    end
    check("rst_sat", sat, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Pass-through with zero coefficients
    commit();
    run_sample(1234, 0, -1, -1);
    run_sample(-5, 0, -1, -1);
    run_sample(32767, 0, -1, -1);

    // First difference
    write_coef(1, -16384);
    commit();
    clear_hist();
    run_sample(100, 0, -1, -1);
    run_sample(300, 0, -1, -1);
    run_sample(250, 0, -1, -1);

    // Positive and negative saturation
    write_coef(1, 16384);
    commit();
    clear_hist();
    run_sample(30000, 0, -1, -1);
    run_sample(30000, 0, -1, -1);
    clear_hist();
    run_sample(-30000, 0, -1, -1);
    run_sample(-30000, 0, -1, -1);

    // Backpressure with a commit deferred from MAC to the next sample
    write_coef(1, -16384);
    run_sample(1000, 5, 2, -1);
    run_sample(500, 0, -1, -1);

    // History clear during MAC: current sample unaffected, next sees zeros
    run_sample(700, 0, -1, ORDER - 1);
    run_sample(300, 0, -1, -1);
    run_sample(200, 2, -1, 3);
    run_sample(50, 0, -1, -1);

    // Same-edge write+commit, and out-of-range addresses ignored
    write_coef(1, 8192);
    wr_commit(1, -8192);
    run_sample(400, 0, -1, -1);
    run_sample(-400, 0, -1, -1);
    write_coef(0, 12345);
    write_coef(ORDER + 1, 12345);
    write_coef(15, -12345);
    commit();
    run_sample(1600, 0, -1, -1);

    // Randomised coefficients and samples
    for (int i = 1; i <= ORDER; i++)
      write_coef(i, int'($urandom_range(16383)) - 8192);
    commit();
    for (int n = 0; n < 14; n++) begin
      xr = int'($urandom_range(40000)) - 20000;
      run_sample(xr, int'($urandom_range(2)), -1, -1);
    end

    // Reset in MAC cycle 4 aborts the sample
    @(negedge clk);
    in_valid = 1'b1; x = 16'sd1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (ORDER + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_output", seen, 0);
    check("midrst_e", e, 0);
    write_coef(1, -16384);
    commit();
    xr = int'($urandom_range(20000)) - 10000;
    run_sample(xr, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lpc_analysis_filt.md
Name: lpc_analysis_filt

Overview:
LPC analysis (inverse, prediction-error) filter. It is the encoder-side counterpart of the LPC synthesis filter. It computes the residual e[n] = x[n] + sum_{k=1..ORDER} a_k * x[n-k] from speech samples, using Q2.14 coefficients. The design is time-multiplexed onto one multiplier-accumulator and uses a valid/ready handshake on both sides. It sits between the sample source and the residual quantiser/encoder, and coefficients are reloaded once per frame.

Parameters:
ORDER, 10, predictor order (number of taps a_1..a_ORDER), 1..15
DW, 16, sample and residual width (signed)
CW, 16, coefficient width (signed Q2.14)
FRAC, 14, coefficient fractional bits
AW, 40, accumulator width (signed)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
in_valid  in  1  sample x valid
in_ready  out  1  block can accept a sample
x  in  DW  input sample, signed
coef_wr  in  1  write coef_data into shadow bank at coef_addr
coef_addr  in  4  tap index 1..ORDER; 0 and >ORDER ignored
coef_data  in  CW  coefficient a_k, signed Q2.14
coef_commit  in  1  pulse: copy shadow bank to active bank
hist_clr  in  1  pulse: zero sample history (frame/utterance start)
out_valid  out  1  residual e valid
out_ready  in  1  downstream accepts e
e  out  DW  residual, signed, saturated
sat  out  1  e on current output was saturated (qualified by out_valid)

Behaviour:
- Reset values:
  - in_ready=0 during rst, 1 in the first cycle after rst deasserts.
  - out_valid=0, e=0, sat=0.
  - FSM=IDLE; accumulator, history hist[1..ORDER], shadow bank, active bank and pending-commit flag all 0.
  - Reset mid-operation aborts the sample in flight; no output is produced for it.
- FSM states IDLE, MAC, OUT:
  - in_ready = (state==IDLE) and not rst.
  - IDLE: on in_valid&in_ready, latch x_reg<=x, set acc<=sign-extended x<<<FRAC, k<=1, go to MAC.
  - MAC: each cycle acc<=acc + active[k]*hist[k] (full CW+DW product, sign-extended to AW), k<=k+1.
  - MAC exit: on the cycle with k==ORDER, go to OUT. On that same edge:
    - e <= sat(acc_final >>> FRAC), arithmetic shift with truncation toward -inf.
    - sat <= overflow flag.
    - shift history: hist[k]<=hist[k-1] for k>=2, hist[1]<=x_reg.
  - OUT: out_valid=1, with e and sat held stable until out_ready. On out_valid&out_ready go to IDLE; out_valid drops next cycle.
- Latency and throughput:
  - Sample accepted at edge T; out_valid first high in cycle T+ORDER+1.
  - Minimum period between accepted samples is ORDER+2 cycles.
- Saturation: if acc>>>FRAC > 2^(DW-1)-1, then e = 2^(DW-1)-1 and sat=1. If it is < -2^(DW-1), then e = -2^(DW-1) and sat=1. Otherwise sat=0.
- Coefficients:
  - coef_wr writes the shadow bank at any time, including while busy.
  - coef_commit in IDLE copies shadow to active on that edge. Any other state sets the pending flag instead; the copy happens on the OUT->IDLE edge and the flag clears.
  - A sample accepted on the same edge as a commit in IDLE uses the new coefficients.
  - The active bank never changes while in MAC/OUT.
  - A simultaneous coef_wr and coef_commit commits the pre-write shadow content.
- History clear:
  - hist_clr zeroes hist on the edge it is seen.
  - If asserted in MAC or OUT, it takes effect after the current sample's history shift, so the next sample sees zero history.
  - The sample in flight is unaffected.
- In OUT, in_valid is ignored and in_ready=0.

Test Plan:
- Reset/idle: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, e=0; in_ready=1 one cycle after release.
- Pass-through: all coefficients 0, commit, feed 1234, -5, 32767 -> e = 1234, -5, 32767; sat=0; out_valid rises exactly ORDER+1=11 cycles after each accept.
- First difference: a_1=-16384 (-1.0), others 0, commit; feed 100, 300, 250 -> e = 100, 200, -50.
- Saturation: a_1=+16384; feed 30000, 30000 -> e = 30000 (sat=0), then 32767 (sat=1). Feed -30000, -30000 after hist_clr -> -30000, then -32768 (sat=1).
- Backpressure and commit deferral: out_ready=0 for 5 cycles in OUT -> e stable, in_ready=0. A new bank (a_1=-16384) committed during MAC is not used by the current sample and is used by the next.
- Reset mid-MAC: assert rst at MAC cycle 4 -> no out_valid. Next sample after reset with a_1 reloaded gives e = x (history zeroed).
